multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle successor to the single-cycle main control decoder. Sequences each RV32 instruction

---
 rtl/ctrl_pkg.sv | 34 +++
 rtl/multicycle_ctrl_fsm_opcode_classify.sv | 28 ++
 rtl/multicycle_ctrl_fsm.sv | 146 ++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, state, class and ALU-op encodings for the multi-cycle control FSM.
// Pure definitions; no logic, no latency.
package ctrl_pkg;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_IMM  = 3'd5
  } class_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_opcode_classify.sv
// Combinational opcode -> {class, legal}; zero latency, no handshake.
// CTRL_IMM_ALU_EN makes the I-type ALU opcode legal.
import ctrl_pkg::*;

module opcode_classify (
  input  logic [6:0] opcode,
  output class_e     op_class,
  output logic       legal
);

  always_comb begin
    op_class = CLS_NONE;
    legal    = 1'b0;
    case (opcode)
      OPC_R:   begin op_class = CLS_R;   legal = 1'b1; end
      OPC_LW:  begin op_class = CLS_LW;  legal = 1'b1; end
      OPC_SW:  begin op_class = CLS_SW;  legal = 1'b1; end
      OPC_BEQ: begin op_class = CLS_BEQ; legal = 1'b1; end
`ifdef CTRL_IMM_ALU_EN
      OPC_IMM: begin op_class = CLS_IMM; legal = 1'b1; end
`else
      OPC_IMM: begin op_class = CLS_NONE; legal = 1'b0; end
`endif
      default: begin op_class = CLS_NONE; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB with mem_ready wait, timeout and sticky TRAP.
// Outputs decode combinationally from state/class (plus mem_ready, zero); CTRL_IMM_ALU_EN adds I-type ALU.
import ctrl_pkg::*;

module multicycle_ctrl_fsm #(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               ir_write,
  output logic               pc_write,
  output logic               trap,
  output logic               busy
);

  localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  class_e dec_class;
  logic   dec_legal;
  logic   wait_expired;
  logic   [CNT_W-1:0] cnt_inc;
  logic   [1:0] alu_op_c;

  opcode_classify u_classify (
    .opcode   (opcode),
    .op_class (dec_class),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      class_q <= CLS_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  // The cycle at count MEM_TIMEOUT-1 is the last wait cycle; mem_ready there still wins.
  assign wait_expired = (cnt_q >= CNT_LAST);
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        if (mem_ready)         state_d = DECODE;
        else if (wait_expired) state_d = TRAP;
        else                   cnt_d   = cnt_inc;
      end
      DECODE: begin
        class_d = dec_class;
        state_d = dec_legal ? EXEC : TRAP;
      end
      EXEC: begin
        case (class_q)
          CLS_R, CLS_IMM:  state_d = WB;
          CLS_LW, CLS_SW:  state_d = MEM;
          CLS_BEQ:         state_d = FETCH;
          default:         state_d = TRAP;
        endcase
      end
      MEM: begin
        if (class_q != CLS_LW && class_q != CLS_SW) state_d = TRAP;
        else if (mem_ready)    state_d = (class_q == CLS_LW) ? WB : FETCH;
        else if (wait_expired) state_d = TRAP;
        else                   cnt_d   = cnt_inc;
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    alu_op_c   = ALUOP_ADD;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    trap       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      EXEC: begin
        case (class_q)
          CLS_R:   alu_op_c = ALUOP_FUNCT;
          CLS_IMM: begin alu_src = 1'b1; alu_op_c = ALUOP_FUNCT; end
          CLS_LW, CLS_SW: begin alu_src = 1'b1; alu_op_c = ALUOP_ADD; end
          CLS_BEQ: begin
            branch   = 1'b1;
            alu_op_c = ALUOP_SUB;
            pc_write = zero;
          end
          default: alu_op_c = ALUOP_ADD;
        endcase
      end
      MEM: begin
        mem_read  = (class_q == CLS_LW);
        mem_write = (class_q == CLS_SW);
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == CLS_LW);
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign alu_op = ALUOP_W'(alu_op_c);
  assign busy   = (state_q != IDLE) && (state_q != TRAP);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: fixed vector table, directed corner sequences, random traffic vs. reference model.
module tb_multicycle_ctrl_fsm;

  localparam int TIMEOUT = 15;
`ifdef CTRL_IMM_ALU_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_LW  = 7'b0000011;
  localparam logic [6:0] O_SW  = 7'b0100011;
  localparam logic [6:0] O_BEQ = 7'b1100011;
  localparam logic [6:0] O_IMM = 7'b0010011;

  logic       clk, rst, start, zero, mem_ready;
  logic [6:0] opcode;
  logic       alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic [1:0] alu_op;
  logic       ir_write, pc_write, trap, busy;
  logic [11:0] obs;

  multicycle_ctrl_fsm #(.ALUOP_W(2), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .alu_op(alu_op), .ir_write(ir_write),
    .pc_write(pc_write), .trap(trap), .busy(busy)
  );

  assign obs = {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op,
                ir_write, pc_write, trap, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [11:0] mk(input logic a_src, input logic m2r, input logic rw,
                                     input logic mrd, input logic mwr, input logic br,
                                     input logic [1:0] aop, input logic irw, input logic pcw,
                                     input logic tr, input logic bz);
    return {a_src, m2r, rw, mrd, mwr, br, aop, irw, pcw, tr, bz};
  endfunction

  // Reference model: instruction phase (0 idle,1 fetch,2 decode,3 exec,4 mem,5 wb,6 trap),
  // instruction kind (1 R,2 LW,3 SW,4 BEQ,5 IMM) and number of cycles already spent waiting.
  int m_phase, m_kind, m_wait;

  function automatic int kind_of(input logic [6:0] o);
    if (o == O_R)   return 1;
    if (o == O_LW)  return 2;
    if (o == O_SW)  return 3;
    if (o == O_BEQ) return 4;
    if (o == O_IMM && IMM_EN) return 5;
    return -1;
  endfunction

  function automatic logic [11:0] model_out(input logic z, input logic mr);
    case (m_phase)
      1: return mk(0, 0, 0, 1, 0, 0, 2'd0, mr, mr, 0, 1);
      2: return mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1);
      3: case (m_kind)
           1: return mk(0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 1);
           2, 3: return mk(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1);
           4: return mk(0, 0, 0, 0, 0, 1, 2'd1, 0, z, 0, 1);
           5: return mk(1, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 1);
           default: return 12'h0;
         endcase
      4: return mk(0, 0, 0, m_kind == 2, m_kind == 3, 0, 2'd0, 0, 0, 0, 1);
      5: return mk(0, m_kind == 2, 1, 0, 0, 0, 2'd0, 0, 0, 0, 1);
      6: return mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0);
      default: return 12'h0;
    endcase
  endfunction

  task automatic model_advance(input logic st, input logic [6:0] opc, input logic mr);
    int nxt;
    int k;
    nxt = m_phase;
    case (m_phase)
      0: if (st) nxt = 1;
      1, 4: begin
        if (mr) nxt = (m_phase == 1) ? 2 : ((m_kind == 2) ? 5 : 1);
        else if (m_wait + 1 >= TIMEOUT) nxt = 6;
      end
      2: begin
        k = kind_of(opc);
        if (k < 0) nxt = 6;
        else begin m_kind = k; nxt = 3; end
      end
      3: nxt = (m_kind == 1 || m_kind == 5) ? 5 : ((m_kind == 4) ? 1 : 4);
      5: nxt = 1;
      default: nxt = m_phase;
    endcase
    if (nxt != m_phase) m_wait = 0;
    else if (m_phase == 1 || m_phase == 4) m_wait++;
    m_phase = nxt;
  endtask

  task automatic step(input logic st, input logic [6:0] opc, input logic z, input logic mr,
                      input string nm);
    @(negedge clk);
    start = st; opcode = opc; zero = z; mem_ready = mr;
    #2;
    check(nm, 32'(obs), 32'(model_out(z, mr)));
    model_advance(st, opc, mr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    #2;
    check("rst_outputs", 32'(obs), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0; m_kind = 0; m_wait = 0;
  endtask

  task automatic to_exec(input logic [6:0] opc);
    step(1'b1, opc, 1'b0, 1'b0, "seq_idle");
    step(1'b0, opc, 1'b0, 1'b1, "seq_fetch");
    step(1'b0, opc, 1'b0, 1'b0, "seq_decode");
  endtask

  typedef struct {
    logic        st;
    logic [6:0]  opc;
    logic        z;
    logic        mr;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n_ir, n_pc, n_rd, n_wr, pct;
    logic [6:0] ro;
    logic [6:0] pick;

    rst = 1'b1; start = 1'b0; opcode = 7'h0; zero = 1'b0; mem_ready = 1'b0;
    m_phase = 0; m_kind = 0; m_wait = 0;

    vecs[0] = '{1'b1, O_R, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'd0,0,0,0,0), "t1_idle"};
    vecs[1] = '{1'b0, O_R, 1'b0, 1'b0, mk(0,0,0,1,0,0,2'd0,0,0,0,1), "t1_fetch_wait"};
    vecs[2] = '{1'b0, O_R, 1'b0, 1'b1, mk(0,0,0,1,0,0,2'd0,1,1,0,1), "t1_fetch_rdy"};
    vecs[3] = '{1'b0, O_R, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'd0,0,0,0,1), "t1_decode"};
    vecs[4] = '{1'b0, O_R, 1'b1, 1'b1, mk(0,0,0,0,0,0,2'd2,0,0,0,1), "t1_exec"};
    vecs[5] = '{1'b0, O_R, 1'b0, 1'b1, mk(0,0,1,0,0,0,2'd0,0,0,0,1), "t1_wb"};
    vecs[6] = '{1'b1, O_R, 1'b0, 1'b0, mk(0,0,0,1,0,0,2'd0,0,0,0,1), "t1_fetch2"};

    #12;
    check("rst_initial", 32'(obs), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: R-type through the fixed vector table.
    n_ir = 0; n_pc = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = vecs[i].st; opcode = vecs[i].opc; zero = vecs[i].z; mem_ready = vecs[i].mr;
      #2;
      check(vecs[i].name, 32'(obs), 32'(vecs[i].exp));
      n_ir += int'(ir_write);
      n_pc += int'(pc_write);
    end
    check("t1_ir_pulses", 32'(n_ir), 32'd1);
    check("t1_pc_pulses", 32'(n_pc), 32'd1);

    // Test 2: LW with mem_ready delayed three cycles in MEM.
    do_reset();
    to_exec(O_LW);
    step(1'b0, O_LW, 1'b0, 1'b0, "t2_exec");
    n_rd = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, O_LW, 1'b0, (i == 3), "t2_mem");
      n_rd += int'(mem_read);
    end
    check("t2_memread_cycles", 32'(n_rd), 32'd4);
    step(1'b0, O_LW, 1'b0, 1'b0, "t2_wb");
    check("t2_wb_m2r_rw", 32'({mem_to_reg, reg_write}), 32'd3);

    // Test 3: BEQ taken then not taken; both return to FETCH.
    step(1'b0, O_BEQ, 1'b0, 1'b1, "t3_fetch_a");
    step(1'b0, O_BEQ, 1'b0, 1'b0, "t3_decode_a");
    step(1'b0, O_BEQ, 1'b1, 1'b0, "t3_exec_z1");
    check("t3_z1_br_op_pc", 32'({branch, alu_op, pc_write}), 32'b1011);
    step(1'b0, O_BEQ, 1'b0, 1'b1, "t3_fetch_b");
    check("t3_back_to_fetch", 32'(mem_read), 32'd1);
    step(1'b0, O_BEQ, 1'b0, 1'b0, "t3_decode_b");
    step(1'b0, O_BEQ, 1'b0, 1'b0, "t3_exec_z0");
    check("t3_z0_br_op_pc", 32'({branch, alu_op, pc_write}), 32'b1010);
    step(1'b0, O_BEQ, 1'b0, 1'b0, "t3_fetch_c");

    // Test 4: SW whose memory never answers.
    do_reset();
    to_exec(O_SW);
    step(1'b0, O_SW, 1'b0, 1'b0, "t4_exec");
    n_wr = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, O_SW, 1'b0, 1'b0, "t4_mem_wait");
      n_wr += int'(mem_write);
    end
    check("t4_memwrite_cycles", 32'(n_wr), 32'd15);
    check("t4_trap_state", 32'(obs), 32'(mk(0,0,0,0,0,0,2'd0,0,0,1,0)));
    step(1'b1, O_R, 1'b1, 1'b1, "t4_trap_sticky");
    do_reset();
    check("t4_trap_cleared", 32'(trap), 32'd0);

    // Test 5: I-type ALU opcode, then the all-zero opcode.
    to_exec(O_IMM);
    step(1'b0, O_IMM, 1'b0, 1'b0, "t5_exec");
    check("t5_trap", 32'(trap), 32'(!IMM_EN));
    check("t5_exec_src_op", 32'({alu_src, alu_op}), IMM_EN ? 32'b110 : 32'b000);
    step(1'b0, O_IMM, 1'b0, 1'b0, "t5_wb");
    check("t5_wb_regwrite", 32'(reg_write), 32'(IMM_EN));
    do_reset();
    to_exec(7'h00);
    step(1'b0, 7'h00, 1'b0, 1'b0, "t5_opc0");
    check("t5_opc0_trap", 32'(trap), 32'd1);

    // Test 6: asynchronous reset in the middle of a store.
    do_reset();
    to_exec(O_SW);
    step(1'b0, O_SW, 1'b0, 1'b0, "t6_exec");
    step(1'b0, O_SW, 1'b0, 1'b0, "t6_mem");
    check("t6_memwrite_before", 32'(mem_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_memwrite_dropped", 32'(mem_write), 32'd0);
    check("t6_all_zero", 32'(obs), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0; m_kind = 0; m_wait = 0;

    // Random traffic against the reference model.
    pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 40 == 0) pct = int'($urandom_range(0, 4)) * 25;
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        ro = 7'($urandom);
        case ($urandom_range(0, 6))
          0: pick = O_R;
          1: pick = O_LW;
          2: pick = O_SW;
          3: pick = O_BEQ;
          4: pick = O_IMM;
          5: pick = 7'h00;
          default: pick = ro;
        endcase
        step(1'($urandom), pick, 1'($urandom),
             (int'($urandom_range(0, 99)) < pct), "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
